load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-stage access engine of the pipelined RV32I core; sits between the E/M pipeline register and pipeline_m_w.
- Takes the address, store data, control and funct3 of the instruction in M.
- Drives a valid/ready data-memory port, and stalls the pipeline while an access is outstanding.
- Delivers the aligned, sign/zero-extended load word as RD to the M/W register.

Parameters:
DATA_WIDTH, 32, data path width (fixed at 32 for RV32I; byte lanes assume 4)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ALUResultM  in  ADDR_WIDTH  byte address of the access
WriteDataM  in  DATA_WIDTH  store data (rs2)
MemReadM  in  1  instruction in M is a load
MemWriteM  in  1  instruction in M is a store
Funct3M  in  3  access size/sign
StallM  out  1  hold IF..M stages this cycle
MemFaultM  out  1  one-cycle pulse: misaligned address or illegal funct3
RD  out  DATA_WIDTH  load result to pipeline_m_w
mem_req  out  1  request valid
mem_we  out  1  1=write
mem_addr  out  ADDR_WIDTH  word-aligned address (addr[1:0]=0)
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_be  out  4  byte enables
mem_ready  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_WIDTH  read word

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata and RD all go to 0.
  - MemFaultM goes to 0. StallM=0 while in IDLE.
- Access = MemReadM | MemWriteM. If both are set, treat the instruction as a store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 value is a fault.
- Misalignment:
  - Half access with addr[0]=1 is a fault.
  - Word access with addr[1:0]!=0 is a fault.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Legal access present: StallM=1 combinationally. Latch addr, we, be, wdata, funct3 and addr[1:0]. Next state REQ.
  - Faulting access: no request. MemFaultM=1 registered (visible the next cycle for one cycle). StallM=0. RD unchanged. Stay in IDLE.
  - No access: StallM=0.
- REQ:
  - StallM=1; mem_req=1 driven from the latched registers; all request outputs held stable until accepted.
  - mem_ready=1: store goes to DONE, load goes to RESP.
- RESP:
  - StallM=1, mem_req=0.
  - mem_rvalid=1: RD <= extracted data, then go to DONE.
  - mem_rvalid is ignored in all other states.
- DONE:
  - StallM=0, so the pipeline advances at this edge. Next state IDLE.
  - The instruction still present in M this cycle is not re-issued.
- Store formatting:
  - SB: wdata={4{WriteDataM[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{WriteDataM[15:0]}}, be=4'b0011<<addr[1:0].
  - SW: wdata=WriteDataM, be=4'b1111.
- Load extraction:
  - Select the byte or half from mem_rdata by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RD holds its value until the next completed load.
- Latency, counted from the cycle the access appears in IDLE until the cycle StallM drops:
  - Store with immediate ready: 3 cycles.
  - Load with immediate ready and rvalid the next cycle: 4 cycles.
  - Each extra cycle without ready or rvalid adds one cycle.
- Reset mid-operation: any state returns to IDLE; the outstanding request is abandoned; RD=0.
- mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}.

Test Plan:
- Reset, then SW addr 0x100, data 0xDEADBEEF, mem_ready tied 1:
  - mem_req=1 for one cycle with be=1111 and addr=0x100.
  - StallM=1,1,0 over the 3 cycles.
- LB addr 0x103, mem_rdata=0x80112233, ready=1, rvalid=1 one cycle after acceptance:
  - RD=0xFFFFFF80.
  - LBU at the same address gives RD=0x00000080.
- SH addr 0x202 data 0x0000ABCD:
  - wdata=0xABCDABCD, be=1100.
  - LHU addr 0x202 with rdata=0xABCD1234 gives RD=0x0000ABCD.
- LW addr 0x101 and LH addr 0x001 (funct3 001, byte offset 1):
  - No mem_req in either case.
  - MemFaultM pulses once per instruction; StallM stays 0; RD unchanged.
  - Illegal funct3 011 gives the same response.
- Back-pressure: LW with mem_ready low 3 cycles, then rvalid low 2 cycles:
  - Request fields stay stable throughout; StallM=1 throughout.
  - Total 9 cycles; RD updates only on rvalid.
- Assert rst_n=0 while in RESP:
  - Next cycle: state IDLE, mem_req=0, StallM=0, RD=0.
  - A late rvalid after reset is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage access engine for the RV32I pipeline. It turns the load or
//   store in M into one valid/ready data-memory transaction. While that
//   transaction is outstanding it holds the pipeline, and it returns the
//   aligned, extended load value on RD.
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   ALUResultM/WriteDataM  byte address and store data of the instruction in M
//   MemReadM/MemWriteM     load/store qualifiers (both set -> store)
//   Funct3M                access size / signedness
//   StallM                 hold IF..M this cycle
//   MemFaultM              one-cycle pulse on misaligned address or illegal funct3
//   RD                     last completed load result
//   mem_*                  data-memory request (req/we/addr/wdata/be, ready)
//                          and response (rvalid/rdata)
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  output logic                  StallM,
  output logic                  MemFaultM,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
  logic [1:0]              off_q, off_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic                    fault_q, fault_d;

  logic                    access, f3_ok, misalign;
  logic [3:0]              be_fmt;
  logic [DATA_WIDTH-1:0]   wdata_fmt, load_val;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;

  // Decode of the instruction currently in M. A store wins when both
  // MemReadM and MemWriteM are set, so MemWriteM alone selects store rules.
  always_comb begin
    access   = MemReadM | MemWriteM;
    if (MemWriteM) f3_ok = !Funct3M[2] && !(Funct3M[1] && Funct3M[0]);
    else           f3_ok = !(Funct3M[1] && Funct3M[0]) && !(Funct3M[2] && Funct3M[1]);
    case (Funct3M[1:0])
      2'b01:   misalign = ALUResultM[0];
      2'b10:   misalign = (ALUResultM[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    case (Funct3M[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << ALUResultM[1:0];
        wdata_fmt = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << ALUResultM[1:0];
        wdata_fmt = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = WriteDataM;
      end
    endcase
  end

  // Lane select uses the offset latched at issue, not the live address.
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'h0, ld_byte};
      3'b101:  load_val = {16'h0, ld_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    fault_d = 1'b0;
    StallM  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (f3_ok && !misalign) begin
            StallM  = 1'b1;
            addr_d  = ALUResultM[ADDR_WIDTH-1:2];
            off_d   = ALUResultM[1:0];
            we_d    = MemWriteM;
            be_d    = MemWriteM ? be_fmt : 4'b0000;
            wdata_d = MemWriteM ? wdata_fmt : '0;
            f3_d    = Funct3M;
            state_d = REQ;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (mem_ready) state_d = we_q ? DONE : RESP;
      end
      RESP: begin
        StallM = 1'b1;
        if (mem_rvalid) begin
          rd_d    = load_val;
          state_d = DONE;
        end
      end
      // Stall released here; the instruction still in M has completed and
      // must not start a second access, so inputs are ignored this cycle.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign RD        = rd_q;
  assign MemFaultM = fault_q;

endmodule
